// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts one
// byte plus odd parity and stop on device clock falls, and checks the ack bit.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 4800,
   parameter int unsigned REQ_CYCLES     = 48,
   parameter int unsigned TIMEOUT_CYCLES = 720000
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       busy,
   output logic       done,
   output logic       err_ack,
   output logic       err_timeout
);

   localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int PW = $clog2(PHASE_MAX + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t          state_q, state_d;
   logic            clk_s1_q, clk_s2_q, clk_hist_q;
   logic            dat_s1_q, dat_s2_q;
   logic [9:0]      shift_q, shift_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [PW-1:0]   phase_cnt_q, phase_cnt_d;
   logic [TW-1:0]   to_cnt_q, to_cnt_d;
   logic            dat_drv_q, dat_drv_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_ack_q, err_ack_d;
   logic            err_to_q, err_to_d;

   logic            fall;
   logic            timeout_hit;

   assign fall        = clk_hist_q & ~clk_s2_q;
   assign timeout_hit = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      phase_cnt_d = phase_cnt_q;
      to_cnt_d    = to_cnt_q;
      dat_drv_d   = dat_drv_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_ack_d   = err_ack_q;
      err_to_d    = err_to_q;

      case (state_q)
         S_IDLE: begin
            if (tx_start) begin
               shift_d     = {1'b1, ~^tx_data, tx_data};
               bit_cnt_d   = '0;
               phase_cnt_d = '0;
               busy_d      = 1'b1;
               err_ack_d   = 1'b0;
               err_to_d    = 1'b0;
               state_d     = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (phase_cnt_q == PW'(INHIBIT_CYCLES - 1)) begin
               phase_cnt_d = '0;
               state_d     = S_REQ;
            end else begin
               phase_cnt_d = phase_cnt_q + 1'b1;
            end
         end
         S_REQ: begin
            if (phase_cnt_q == PW'(REQ_CYCLES - 1)) begin
               phase_cnt_d = '0;
               to_cnt_d    = '0;
               dat_drv_d   = 1'b1;
               state_d     = S_SHIFT;
            end else begin
               phase_cnt_d = phase_cnt_q + 1'b1;
            end
         end
         S_SHIFT, S_ACK, S_WAIT_IDLE: begin
            to_cnt_d = to_cnt_q + 1'b1;
            // Timeout takes priority over a fall landing in the same cycle.
            if (timeout_hit) begin
               err_to_d  = 1'b1;
               busy_d    = 1'b0;
               dat_drv_d = 1'b0;
               state_d   = S_IDLE;
            end else if (state_q == S_SHIFT) begin
               if (fall) begin
                  dat_drv_d = ~shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 4'd9) state_d = S_ACK;
               end
            end else if (state_q == S_ACK) begin
               if (fall) begin
                  if (!dat_s2_q) begin
                     state_d = S_WAIT_IDLE;
                  end else begin
                     err_ack_d = 1'b1;
                     busy_d    = 1'b0;
                     state_d   = S_IDLE;
                  end
               end
            end else begin
               if (clk_s2_q && dat_s2_q) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         clk_hist_q  <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         phase_cnt_q <= '0;
         to_cnt_q    <= '0;
         dat_drv_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_ack_q   <= 1'b0;
         err_to_q    <= 1'b0;
      end else begin
         clk_s1_q    <= ps2_clk_in;
         clk_s2_q    <= clk_s1_q;
         clk_hist_q  <= clk_s2_q;
         dat_s1_q    <= ps2_dat_in;
         dat_s2_q    <= dat_s1_q;
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         phase_cnt_q <= phase_cnt_d;
         to_cnt_q    <= to_cnt_d;
         dat_drv_q   <= dat_drv_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_ack_q   <= err_ack_d;
         err_to_q    <= err_to_d;
      end
   end

   // Line drives decode straight from state so reset releases them without waiting for an edge.
   assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
   assign ps2_dat_oe  = (state_q == S_REQ) || ((state_q == S_SHIFT) && dat_drv_q);
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_ack     = err_ack_q;
   assign err_timeout = err_to_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain pad model, a PS/2 device
// model that clocks the frame, and a frame-level reference of the sent bits.
module tb_ps2_host_tx;

   localparam int I_CYC = 40;
   localparam int R_CYC = 8;
   localparam int T_CYC = 2000;
   localparam int HALF  = 20;

   logic       clk_sys     = 1'b0;
   logic       reset_n     = 1'b0;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       tx_start    = 1'b0;
   logic [7:0] tx_data     = 8'h00;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe, busy, done, err_ack, err_timeout;

   int n_chk      = 0;
   int n_pass     = 0;
   int done_total = 0;

   // Wired-AND open-drain lines with pull-ups.
   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(I_CYC),
      .REQ_CYCLES    (R_CYC),
      .TIMEOUT_CYCLES(T_CYC)
   ) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .busy       (busy),
      .done       (done),
      .err_ack    (err_ack),
      .err_timeout(err_timeout)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) if (done === 1'b1) done_total <= done_total + 1;

   typedef struct {
      logic [7:0] data;
      bit         ack;
      logic [9:0] exp_bits;
      bit         exp_done;
      bit         exp_err_ack;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Line levels after falls 1..10, bit n-1 = level after fall n.
   function automatic logic [9:0] model_frame(input logic [7:0] d);
      logic [9:0] lv;
      for (int i = 0; i < 8; i++) lv[i] = ((d >> i) % 2) != 0;
      lv[8] = ($countones(d) % 2) == 0;
      lv[9] = 1'b1;
      return lv;
   endfunction

   // Pulse tx_start and watch the lines until the host releases the clock.
   task automatic start_and_measure(input logic [7:0] d, output int lat, output int inh,
                                    output int req, output logic [1:0] errs_at_accept);
      @(negedge clk_sys);
      tx_data  = d;
      tx_start = 1'b1;
      lat = 0; inh = 0; req = 0; errs_at_accept = 2'b11;
      do begin
         @(negedge clk_sys);
         tx_start = 1'b0;
         lat++;
         if (lat == 1) errs_at_accept = {err_ack, err_timeout};
         if (ps2_clk_oe && !ps2_dat_oe) inh++;
         else if (ps2_clk_oe && ps2_dat_oe) req++;
      end while (ps2_clk_oe && lat < I_CYC + R_CYC + 50);
   endtask

   // Device side: wait for request-to-send, clock 11 bits, optionally ack.
   // With abort_at > 0 it returns holding the clock low after that fall.
   task automatic device_frame(input bit ack, input int abort_at, output logic [9:0] bits, output bit seen);
      bits = '0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_sys);
         if (ps2_clk_in && !ps2_dat_in) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) return;
      repeat (HALF) @(negedge clk_sys);
      for (int n = 1; n <= 11; n++) begin
         if (n == 11 && ack) begin
            dev_dat_low = 1'b1;
            repeat (4) @(negedge clk_sys);
         end
         dev_clk_low = 1'b1;
         if (n == abort_at) begin
            repeat (6) @(negedge clk_sys);
            return;
         end
         repeat (HALF) @(negedge clk_sys);
         if (n <= 10) bits[n-1] = ps2_dat_in;
         dev_clk_low = 1'b0;
         repeat (HALF) @(negedge clk_sys);
         if (n == 11) dev_dat_low = 1'b0;
      end
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (busy && k < 300) begin
         @(negedge clk_sys);
         k++;
      end
      if (busy) $display("FAIL %s_idle_wait: busy still 1 after %0d cycles, expected 0", tag, k);
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic run_frame(input logic [7:0] d, input bit ack, input logic [9:0] exp_bits,
                            input bit exp_done, input bit exp_err_ack, input string tag);
      int lat, inh, req, d0;
      logic [1:0] errs;
      logic [9:0] bits;
      bit seen;
      d0 = done_total;
      start_and_measure(d, lat, inh, req, errs);
      check({tag, "_release_latency"}, lat, I_CYC + R_CYC + 1);
      check({tag, "_inhibit_cycles"}, inh, I_CYC);
      check({tag, "_req_cycles"}, req, R_CYC);
      check({tag, "_errs_cleared_on_start"}, {30'd0, errs}, 0);
      device_frame(ack, 0, bits, seen);
      check({tag, "_rts_seen"}, {31'd0, seen}, 1);
      wait_idle(tag);
      check({tag, "_bits"}, {22'd0, bits}, {22'd0, exp_bits});
      check({tag, "_done_pulses"}, done_total - d0, {31'd0, exp_done});
      check({tag, "_err_ack"}, {31'd0, err_ack}, {31'd0, exp_err_ack});
      check({tag, "_err_timeout"}, {31'd0, err_timeout}, 0);
      check({tag, "_busy"}, {31'd0, busy}, 0);
      check({tag, "_lines_released"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
   endtask

   initial begin : main
      int lat, inh, req, d0, k, cnt;
      logic [1:0] errs;
      logic [9:0] bits;
      bit seen;
      logic [7:0] rd;
      bit ra;

      vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1'b1, 1'b0};
      vecs[1] = '{8'hF4, 1'b1, 10'h2F4, 1'b1, 1'b0};
      vecs[2] = '{8'h01, 1'b0, 10'h201, 1'b0, 1'b1};
      for (int i = 3; i < 8; i++) begin
         rd = 8'($urandom_range(0, 255));
         ra = ($urandom_range(0, 3) != 0);
         vecs[i] = '{rd, ra, model_frame(rd), ra, !ra};
      end

      #12;
      check("reset_outputs", {26'd0, ps2_clk_oe, ps2_dat_oe, busy, done, err_ack, err_timeout}, 0);
      @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);

      for (int i = 0; i < 8; i++)
         run_frame(vecs[i].data, vecs[i].ack, vecs[i].exp_bits, vecs[i].exp_done,
                   vecs[i].exp_err_ack, $sformatf("vec%0d", i));

      // Device never clocks: timeout exactly T_CYC cycles after clock release.
      d0 = done_total;
      start_and_measure(8'h3C, lat, inh, req, errs);
      k = 0;
      while (err_timeout !== 1'b1 && k < T_CYC + 50) begin
         @(negedge clk_sys);
         k++;
      end
      check("timeout_cycles", k, T_CYC);
      check("timeout_busy", {31'd0, busy}, 0);
      check("timeout_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
      check("timeout_no_done", done_total - d0, 0);
      run_frame(8'h3C, 1'b1, model_frame(8'h3C), 1'b1, 1'b0, "after_timeout");

      // tx_start during a busy frame is ignored.
      d0 = done_total;
      start_and_measure(8'hAA, lat, inh, req, errs);
      fork
         device_frame(1'b1, 0, bits, seen);
         begin
            repeat (150) @(negedge clk_sys);
            tx_data  = 8'h55;
            tx_start = 1'b1;
            @(negedge clk_sys);
            tx_start = 1'b0;
         end
      join
      wait_idle("busy_ignore");
      check("busy_ignore_bits", {22'd0, bits}, {22'd0, model_frame(8'hAA)});
      check("busy_ignore_done", done_total - d0, 1);
      cnt = 0;
      for (int j = 0; j < 2 * (I_CYC + R_CYC) + 20; j++) begin
         @(negedge clk_sys);
         if (ps2_clk_oe) cnt++;
      end
      check("busy_ignore_no_second_frame", cnt, 0);

      // Reset at fall 5 of 0xED (D4 = 0, data line driven low).
      start_and_measure(8'hED, lat, inh, req, errs);
      device_frame(1'b1, 5, bits, seen);
      check("pre_reset_dat_oe", {31'd0, ps2_dat_oe}, 1);
      check("pre_reset_busy", {31'd0, busy}, 1);
      #1 reset_n = 1'b0;
      #1;
      check("async_reset_outputs", {26'd0, ps2_clk_oe, ps2_dat_oe, busy, done, err_ack, err_timeout}, 0);
      dev_clk_low = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      run_frame(8'hED, 1'b1, 10'h3ED, 1'b1, 1'b0, "after_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte from the core to the attached keyboard, for example 0xED (set LEDs) or 0xF4 (enable), using the standard request-to-send sequence. It is the transmit counterpart of the keyboard receive path and sits beside keyboard on the clk_sys domain. The pad level implements the PS/2 lines as open-drain: an oe output of 1 pulls the line low, and 0 releases it.

Parameters:
INHIBIT_CYCLES, 4800, clk_sys cycles the clock line is held low before the request (100 us at 48 MHz).
REQ_CYCLES, 48, clk_sys cycles data and clock are both held low before the clock is released (1 us).
TIMEOUT_CYCLES, 720000, maximum clk_sys cycles from clock release to completion (15 ms).

Ports:
clk_sys  in  1  system clock, 48 MHz; all logic is on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
ps2_clk_in  in  1  raw PS/2 clock line level; asynchronous.
ps2_dat_in  in  1  raw PS/2 data line level; asynchronous.
ps2_clk_oe  out  1  1 = drive the clock line low.
ps2_dat_oe  out  1  1 = drive the data line low.
tx_data  in  8  byte to send; sampled on the accepted start.
tx_start  in  1  one-cycle request strobe.
busy  out  1  high from the accepted start until done or an error.
done  out  1  one-cycle pulse on successful completion.
err_ack  out  1  sticky: the device did not acknowledge.
err_timeout  out  1  sticky: the transfer exceeded TIMEOUT_CYCLES.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - all outputs are 0; the FSM goes to IDLE; the counters and the bit index are cleared.
  - Reset asserted mid-transfer releases both lines immediately.
- Input synchronisation: ps2_clk_in and ps2_dat_in each pass through 2 flops, plus one history flop on the clock.
  - fall = previous synchronised clock 1 and current synchronised clock 0.
  - All sampling uses the synchronised values only.
- Start acceptance:
  - tx_start in IDLE latches the shift register = {1'b1 stop, odd parity, tx_data}. Odd parity is the inverse of the XOR reduction of tx_data.
  - The same acceptance clears err_ack and err_timeout, sets busy, and enters INHIBIT on the next cycle.
  - tx_start while busy=1 is ignored; the latched byte is unchanged.
- FSM states:
  - IDLE: clk_oe=0, dat_oe=0.
  - INHIBIT: clk_oe=1, dat_oe=0, for exactly INHIBIT_CYCLES cycles, then REQ.
  - REQ: clk_oe=1, dat_oe=1 (start bit 0), for REQ_CYCLES cycles, then SHIFT. The timeout counter clears at this point.
  - SHIFT: clk_oe=0; dat_oe holds the start bit (1) until the first fall.
    - On each fall n=1..10, set dat_oe = ~bit, where bit is taken LSB first: falls 1-8 carry D0-D7, fall 9 carries parity, fall 10 carries stop (dat_oe=0).
    - After fall 10, go to ACK.
  - ACK: on the next fall (the 11th), sample synchronised data.
    - Data 0 means acknowledged: go to WAIT_IDLE.
    - Data 1: set err_ack, clear busy, go to IDLE.
  - WAIT_IDLE: wait until the synchronised clock and data are both 1. Then pulse done for 1 cycle, clear busy, go to IDLE.
- Timeout:
  - The counter runs in SHIFT, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES-1: set err_timeout, release both lines, clear busy, go to IDLE. done is not pulsed.
  - If a fall arrives in the same cycle as the timeout, the timeout wins.
- Latency: clock release occurs INHIBIT_CYCLES+REQ_CYCLES+1 cycles after the accepted tx_start.
- Bit changes land only in the cycle after the synchronised fall, about 3 clk_sys after the pad edge, which is well inside the device low phase.
- Back-to-back: tx_start is accepted in the first IDLE cycle after done.
- A fall seen during INHIBIT or REQ (device mid-transmission) is ignored; INHIBIT aborts the device frame by protocol.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and pulling data low on the 11th clock. The levels driven after falls 1..10 must be 1,0,1,1,0,1,1,1, parity 1, stop 1. Then done=1 for 1 cycle, busy=0, both errors 0.
- Send 0xF4 with the same model. The expected bits are 0,0,1,0,1,1,1,1 and parity 0. Check that clock release occurs exactly INHIBIT_CYCLES+REQ_CYCLES+1 cycles after tx_start, and that clk_oe stays high throughout INHIBIT.
- Send 0x01 with a model that leaves data high on the 11th clock. Require err_ack=1, done=0, busy=0, both lines released, parity bit sent = 0.
- Model never clocks after the request. Exactly TIMEOUT_CYCLES cycles after entering SHIFT: err_timeout=1, busy=0, clk_oe=dat_oe=0. A following tx_start clears err_timeout.
- Pulse tx_start with 0x55 during busy, mid-transfer of 0xAA. The transmitted data must remain 0xAA and no second frame may follow.
- Assert reset_n=0 at fall 5 of a frame. All outputs must be 0 asynchronously, before the next clk_sys edge. After release, a new 0xED frame must complete normally.
